uart_rx_fifo: RTL



---
 rtl/uart_rx_fifo_pkg.sv | 30 +++
 rtl/fifo_mem.sv | 26 ++
 rtl/uart_rx_fifo.sv | 86 ++++++++
 3 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART receive-path constants: data width, default FIFO sizing and
// status-register bit positions used by the bus interface.
package uart_rx_fifo_pkg;

   localparam int UART_DATA_W     = 8;
   localparam int RX_FIFO_DEPTH   = 16;
   localparam int RX_FIFO_ADDR_W  = 4;
   localparam int RX_FIFO_THRESH  = 8;

   localparam int STAT_RX_AVAIL_BIT = 0;
   localparam int STAT_OVERFLOW_BIT = 1;
   localparam int STAT_LEVEL_BIT    = 2;

   typedef struct packed {
      logic rx_available;
      logic overflow;
      logic level_hit;
   } rx_status_t;

   // Places the FIFO flags at their status-register bit positions.
   function automatic logic [7:0] pack_rx_status(input rx_status_t st);
      logic [7:0] word;
      word                    = 8'h00;
      word[STAT_RX_AVAIL_BIT] = st.rx_available;
      word[STAT_OVERFLOW_BIT] = st.overflow;
      word[STAT_LEVEL_BIT]    = st.level_hit;
      return word;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W register array: synchronous write, asynchronous read.
// Shared by the RX and TX FIFOs; holds no reset since contents are don't-care.
module fifo_mem
   import uart_rx_fifo_pkg::*;
#(
   parameter int DEPTH  = RX_FIFO_DEPTH,
   parameter int ADDR_W = RX_FIFO_ADDR_W,
   parameter int DATA_W = UART_DATA_W
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: circular first-word-fall-through byte FIFO with
// count, threshold, full/empty and sticky overflow reporting.
module uart_rx_fifo
   import uart_rx_fifo_pkg::*;
#(
   parameter int DEPTH  = RX_FIFO_DEPTH,
   parameter int ADDR_W = RX_FIFO_ADDR_W,
   parameter int THRESH = RX_FIFO_THRESH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [UART_DATA_W-1:0] wr_data,
   input  logic                   wr_valid,
   input  logic                   rd_en,
   input  logic                   flush,
   input  logic                   clr_ovf,
   output logic [UART_DATA_W-1:0] rd_data,
   output logic                   empty,
   output logic                   full,
   output logic [ADDR_W:0]        count,
   output logic                   level_hit,
   output logic                   overflow
);

   localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] THRESH_C = (ADDR_W+1)'(THRESH);

   logic [ADDR_W-1:0]      wr_ptr;
   logic [ADDR_W-1:0]      rd_ptr;
   logic [ADDR_W:0]        count_q;
   logic                   overflow_q;
   logic                   do_pop;
   logic                   do_push;
   logic                   drop;
   logic [UART_DATA_W-1:0] mem_rdata;

   // A pop frees the slot, so a push into a full FIFO with a pop is accepted.
   assign do_pop  = rd_en && (count_q != '0);
   assign do_push = wr_valid && ((count_q != DEPTH_C) || do_pop);
   assign drop    = wr_valid && !do_push;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else if (flush) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + ADDR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (ADDR_W+1)'(1);
            2'b01:   count_q <= count_q - (ADDR_W+1)'(1);
            default: count_q <= count_q;
         endcase
         if (drop)         overflow_q <= 1'b1;
         else if (clr_ovf) overflow_q <= 1'b0;
      end
   end

   fifo_mem #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (UART_DATA_W)
   ) u_mem (
      .clk   (clk),
      .we    (do_push && !flush),
      .waddr (wr_ptr),
      .wdata (wr_data),
      .raddr (rd_ptr),
      .rdata (mem_rdata)
   );

   assign count     = count_q;
   assign empty     = (count_q == '0);
   assign full      = (count_q == DEPTH_C);
   assign level_hit = (count_q >= THRESH_C);
   assign overflow  = overflow_q;
   assign rd_data   = empty ? '0 : mem_rdata;

endmodule
